bus_master_arbiter: RTL and testbench



---
 rtl/bus_master_arbiter_pkg.sv | 14 +
 rtl/bus_master_mux.sv | 51 +++++
 rtl/bus_master_arbiter.sv | 135 +++++++++++++
 tb/tb_bus_master_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_master_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter: state encoding and
// default bus widths matching the system Bus master port.
package bus_master_arbiter_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT0 = 2'b01,
        ST_GNT1 = 2'b10
    } arb_state_t;

endpackage

// File: rtl/bus_master_mux.sv
// Combinational request/data steering between the two masters and the Bus
// master port. The arbiter state alone selects the path; nothing is
// registered here, so the Bus data timing passes through unchanged.
module bus_master_mux
    import bus_master_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [1:0]        i_state,
    input  logic              i_m0_req,
    input  logic              i_m0_wr,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_dout,
    input  logic              i_m1_req,
    input  logic              i_m1_wr,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_dout,
    input  logic [DATA_W-1:0] i_b_din,
    output logic              o_b_req,
    output logic              o_b_wr,
    output logic [ADDR_W-1:0] o_b_addr,
    output logic [DATA_W-1:0] o_b_dout,
    output logic [DATA_W-1:0] o_m0_din,
    output logic [DATA_W-1:0] o_m1_din
);

    // Route the granted master onto the Bus; everything is zero when idle.
    always_comb begin
        o_b_req  = 1'b0;
        o_b_wr   = 1'b0;
        o_b_addr = '0;
        o_b_dout = '0;
        o_m0_din = '0;
        o_m1_din = '0;
        if (i_state == ST_GNT0) begin
            o_b_req  = i_m0_req;
            o_b_wr   = i_m0_wr;
            o_b_addr = i_m0_addr;
            o_b_dout = i_m0_dout;
            o_m0_din = i_b_din;
        end else if (i_state == ST_GNT1) begin
            o_b_req  = i_m1_req;
            o_b_wr   = i_m1_wr;
            o_b_addr = i_m1_addr;
            o_b_dout = i_m1_dout;
            o_m1_din = i_b_din;
        end
    end

endmodule

// File: rtl/bus_master_arbiter.sv
// Two-master arbiter in front of the Bus master port. Round-robin on ties,
// the holder keeps the bus while requesting, and a tenure limit forces a
// handover when the other master has been waiting (MAX_HOLD = 0 disables it).
module bus_master_arbiter
    import bus_master_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_dout,
    output logic              m0_grant,
    output logic [DATA_W-1:0] m0_din,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_dout,
    output logic              m1_grant,
    output logic [DATA_W-1:0] m1_din,
    output logic              b_req,
    output logic              b_wr,
    output logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_dout,
    input  logic [DATA_W-1:0] b_din
);

    // With MAX_HOLD = 0 the counter is unused; keep it one bit wide so the
    // declaration stays legal.
    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic             r_last;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             w_hold_expired;
    logic             w_state_change;

    assign w_hold_expired = (MAX_HOLD > 0) && (r_hold_cnt == HOLD_LAST);
    assign w_state_change = (w_next_state != r_state);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: tie-break against the last master served, direct handover
    // when the holder releases, preemption once the tenure limit is reached.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (m0_req && m1_req) begin
                    w_next_state = r_last ? ST_GNT0 : ST_GNT1;
                end else if (m0_req) begin
                    w_next_state = ST_GNT0;
                end else if (m1_req) begin
                    w_next_state = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (!m0_req) begin
                    w_next_state = m1_req ? ST_GNT1 : ST_IDLE;
                end else if (m1_req && w_hold_expired) begin
                    w_next_state = ST_GNT1;
                end
            end
            ST_GNT1: begin
                if (!m1_req) begin
                    w_next_state = m0_req ? ST_GNT0 : ST_IDLE;
                end else if (m0_req && w_hold_expired) begin
                    w_next_state = ST_GNT0;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Tenure counter: restarts on every grant change, saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_cnt <= '0;
        end else if (w_state_change || r_state == ST_IDLE) begin
            r_hold_cnt <= '0;
        end else if (r_hold_cnt != HOLD_LAST) begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
        end
    end

    // Remember which master was most recently granted for tie-breaking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (w_state_change && w_next_state == ST_GNT0) begin
            r_last <= 1'b0;
        end else if (w_state_change && w_next_state == ST_GNT1) begin
            r_last <= 1'b1;
        end
    end

    assign m0_grant = (r_state == ST_GNT0);
    assign m1_grant = (r_state == ST_GNT1);

    bus_master_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .i_state   (r_state),
        .i_m0_req  (m0_req),
        .i_m0_wr   (m0_wr),
        .i_m0_addr (m0_addr),
        .i_m0_dout (m0_dout),
        .i_m1_req  (m1_req),
        .i_m1_wr   (m1_wr),
        .i_m1_addr (m1_addr),
        .i_m1_dout (m1_dout),
        .i_b_din   (b_din),
        .o_b_req   (b_req),
        .o_b_wr    (b_wr),
        .o_b_addr  (b_addr),
        .o_b_dout  (b_dout),
        .o_m0_din  (m0_din),
        .o_m1_din  (m1_din)
    );

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Bench for bus_master_arbiter: two instances (tenure limit 4 and no limit)
// share one set of master/Bus inputs; each is compared every cycle against
// an owner/tenure model, plus directed checks on the listed scenarios.
module tb_bus_master_arbiter;

    localparam int AW = 16;
    localparam int DW = 64;

    logic          clk;
    logic          reset;
    logic          m0_req, m0_wr, m1_req, m1_wr;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_dout, m1_dout, b_din;

    logic          h4_m0_grant, h4_m1_grant, h4_b_req, h4_b_wr;
    logic [AW-1:0] h4_b_addr;
    logic [DW-1:0] h4_b_dout, h4_m0_din, h4_m1_din;
    logic          h0_m0_grant, h0_m1_grant, h0_b_req, h0_b_wr;
    logic [AW-1:0] h0_b_addr;
    logic [DW-1:0] h0_b_dout, h0_m0_din, h0_m1_din;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: owner (-1 none), last master granted, cycles held so far.
    int own4, last4, ten4;
    int own0, last0, ten0;

    bus_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(4)) u_h4 (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout),
        .m0_grant(h4_m0_grant), .m0_din(h4_m0_din),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout),
        .m1_grant(h4_m1_grant), .m1_din(h4_m1_din),
        .b_req(h4_b_req), .b_wr(h4_b_wr), .b_addr(h4_b_addr), .b_dout(h4_b_dout),
        .b_din(b_din)
    );

    bus_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(0)) u_h0 (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout),
        .m0_grant(h0_m0_grant), .m0_din(h0_m0_din),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout),
        .m1_grant(h0_m1_grant), .m1_din(h0_m1_din),
        .b_req(h0_b_req), .b_wr(h0_b_wr), .b_addr(h0_b_addr), .b_dout(h0_b_dout),
        .b_din(b_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Who owns the bus after the next edge, from the arbitration rules.
    task automatic model_next(input int max_hold, inout int own, inout int last, inout int ten);
        int nown;
        logic rh, ro;
        if (reset) begin
            own = -1; last = 1; ten = 0;
        end else begin
            nown = own;
            if (own < 0) begin
                if (m0_req && m1_req) nown = 1 - last;
                else if (m0_req)      nown = 0;
                else if (m1_req)      nown = 1;
            end else begin
                rh = (own == 0) ? m0_req : m1_req;
                ro = (own == 0) ? m1_req : m0_req;
                if (!rh)                                   nown = ro ? 1 - own : -1;
                else if (max_hold > 0 && ro && ten >= max_hold) nown = 1 - own;
            end
            if (nown != own) begin
                ten = (nown < 0) ? 0 : 1;
                if (nown >= 0) last = nown;
            end else if (nown >= 0) begin
                ten++;
            end
            own = nown;
        end
    endtask

    task automatic check_dut(input string nm, input int own,
                             input logic g0, input logic g1, input logic breq, input logic bwr,
                             input logic [AW-1:0] baddr, input logic [DW-1:0] bdout,
                             input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        logic          e_req, e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_dout;
        e_req  = (own == 0) ? m0_req  : (own == 1) ? m1_req  : 1'b0;
        e_wr   = (own == 0) ? m0_wr   : (own == 1) ? m1_wr   : 1'b0;
        e_addr = (own == 0) ? m0_addr : (own == 1) ? m1_addr : '0;
        e_dout = (own == 0) ? m0_dout : (own == 1) ? m1_dout : '0;
        chk({nm, ".m0_grant"}, 64'(g0), 64'(own == 0));
        chk({nm, ".m1_grant"}, 64'(g1), 64'(own == 1));
        chk({nm, ".b_req"}, 64'(breq), 64'(e_req));
        chk({nm, ".b_wr"}, 64'(bwr), 64'(e_wr));
        chk({nm, ".b_addr"}, 64'(baddr), 64'(e_addr));
        chk({nm, ".b_dout"}, bdout, e_dout);
        chk({nm, ".m0_din"}, d0, (own == 0) ? b_din : 64'd0);
        chk({nm, ".m1_din"}, d1, (own == 1) ? b_din : 64'd0);
    endtask

    // One clock: advance models on the pre-edge inputs, then check at negedge.
    task automatic step();
        model_next(4, own4, last4, ten4);
        model_next(0, own0, last0, ten0);
        @(posedge clk);
        @(negedge clk);
        check_dut("h4", own4, h4_m0_grant, h4_m1_grant, h4_b_req, h4_b_wr,
                  h4_b_addr, h4_b_dout, h4_m0_din, h4_m1_din);
        check_dut("h0", own0, h0_m0_grant, h0_m1_grant, h0_b_req, h0_b_wr,
                  h0_b_addr, h0_b_dout, h0_m0_din, h0_m1_din);
    endtask

    initial begin
        own4 = -1; last4 = 1; ten4 = 0;
        own0 = -1; last0 = 1; ten0 = 0;
        reset = 1'b1;
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 16'h0; m0_dout = 64'h0;
        m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 16'h0200; m1_dout = 64'h5A5A;
        b_din = 64'hBEEF;

        // Reset held two cycles with both masters requesting.
        step();
        chk("rst1.m0_grant", 64'(h4_m0_grant), 64'd0);
        chk("rst1.b_req", 64'(h4_b_req), 64'd0);
        step();
        chk("rst2.m1_grant", 64'(h4_m1_grant), 64'd0);
        chk("rst2.b_addr", 64'(h4_b_addr), 64'd0);

        // Single write request from IDLE.
        reset = 1'b0; m1_req = 1'b0;
        m0_addr = 16'h0010; m0_wr = 1'b1; m0_dout = 64'hA5;
        step();
        chk("wr.m0_grant", 64'(h4_m0_grant), 64'd1);
        chk("wr.b_addr", 64'(h4_b_addr), 64'h10);
        chk("wr.b_wr", 64'(h4_b_wr), 64'd1);
        chk("wr.b_dout", h4_b_dout, 64'hA5);
        chk("wr.m1_din", h4_m1_din, 64'd0);

        // Tie after reset goes to m0, then direct handover, then tie again.
        reset = 1'b1;
        step();
        reset = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
        step();
        chk("tie1.m0_grant", 64'(h4_m0_grant), 64'd1);
        m0_req = 1'b0;
        step();
        chk("handover.m1_grant", 64'(h4_m1_grant), 64'd1);
        m1_req = 1'b0;
        step();
        chk("idle.m1_grant", 64'(h4_m1_grant), 64'd0);
        m0_req = 1'b1; m1_req = 1'b1;
        step();
        chk("tie2.m0_grant", 64'(h4_m0_grant), 64'd1);

        // Continuous contention: limit-4 instance alternates every 4 cycles.
        for (int i = 0; i < 12; i++) begin
            step();
            chk("rr.m1_grant", 64'(h4_m1_grant), 64'((((i + 1) / 4) % 2) == 1));
            chk("rr.b_addr", 64'(h4_b_addr), ((((i + 1) / 4) % 2) == 1) ? 64'h0200 : 64'h10);
            chk("nolimit.m0_grant", 64'(h0_m0_grant), 64'd1);
        end

        // Read data returned only to the granted master, then reset mid-tenure.
        m0_req = 1'b0; m1_req = 1'b1; b_din = 64'h1234;
        step();
        chk("rd.m1_din", h4_m1_din, 64'h1234);
        chk("rd.m0_din", h4_m0_din, 64'd0);
        reset = 1'b1;
        step();
        chk("rst_mid.m1_grant", 64'(h4_m1_grant), 64'd0);
        chk("rst_mid.b_req", 64'(h4_b_req), 64'd0);
        chk("rst_mid.m1_din", h4_m1_din, 64'd0);

        // No-limit instance keeps m0 for 50 cycles while m1 waits.
        reset = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("hold50.m0_grant", 64'(h0_m0_grant), 64'd1);
        end
        m0_req = 1'b0;
        step();
        chk("hold50.release", 64'(h0_m1_grant), 64'd1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            reset   = ($urandom_range(0, 39) == 0);
            m0_req  = ($urandom_range(0, 3) != 0);
            m1_req  = ($urandom_range(0, 3) != 0);
            m0_wr   = 1'($urandom);
            m1_wr   = 1'($urandom);
            m0_addr = 16'($urandom);
            m1_addr = 16'($urandom);
            m0_dout = {$urandom, $urandom};
            m1_dout = {$urandom, $urandom};
            b_din   = {$urandom, $urandom};
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
